// File: rtl/spike_packet_router.sv
// spike_packet_router: fans captured spikes out as {source, destination} packets by walking a CSR table
// Ports: CLK/RESET (async, active-high); clear flushes pending spikes and aborts the walk;
// spikes are one-cycle pulses per neuron; cfg_we/cfg_sel/cfg_addr/cfg_data write the naddr/ptr/conn
// tables while idle; packet/packet_valid/packet_ready form the output handshake; busy marks LOAD/EMIT;
// done pulses when the final pending neuron completes.
module spike_packet_router #(
  parameter int N_NEURONS  = 10,
  parameter int ADDR_W     = 12,
  parameter int CONN_DEPTH = 32,
  parameter int PTR_W      = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  clear,
  input  logic [N_NEURONS-1:0]  spikes,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [PTR_W-1:0]      cfg_addr,
  input  logic [ADDR_W-1:0]     cfg_data,
  output logic [2*ADDR_W-1:0]   packet,
  output logic                  packet_valid,
  input  logic                  packet_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int IW = $clog2(N_NEURONS + 1);
  localparam int NW = $clog2(N_NEURONS);
  localparam int CW = $clog2(CONN_DEPTH);
  localparam logic [PTR_W-1:0] N_P = PTR_W'(N_NEURONS);
  localparam logic [PTR_W-1:0] D_P = PTR_W'(CONN_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] naddr [N_NEURONS];
  logic [PTR_W-1:0]  ptr   [N_NEURONS+1];
  logic [ADDR_W-1:0] conn  [CONN_DEPTH];
  logic [N_NEURONS-1:0] pending, load_clr, rem;
  logic [IW-1:0] sel, cur;
  logic [PTR_W-1:0] j, end_r, j_n, end_n, p_hi;
  logic has, empty, fire, last, done_n;
  always_comb begin
    sel = '0;
    for (int k = N_NEURONS - 1; k >= 0; k--)
      if (pending[k]) sel = IW'(k);
  end
  assign has      = |pending;
  assign load_clr = (state == LOAD && has) ? N_NEURONS'(1) << sel : '0;
  assign rem      = pending & ~load_clr;
  assign j_n      = ptr[sel];
  assign p_hi     = ptr[sel + IW'(1)];
  // pointers beyond the table are clamped so a bad ptr never walks off the end
  assign end_n    = p_hi > D_P ? D_P : p_hi;
  assign empty    = !has || j_n >= end_n;
  assign packet_valid = state == EMIT;
  assign busy     = state != IDLE;
  assign fire     = packet_valid && packet_ready;
  assign last     = (j + PTR_W'(1)) == end_r;
  assign packet   = packet_valid ? {naddr[cur[NW-1:0]], conn[j[CW-1:0]]} : '0;
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    if (state == IDLE) state_n = has && !clear ? LOAD : IDLE;
    else if (clear) state_n = IDLE;
    else if (state == LOAD) begin
      state_n = !empty ? EMIT : |rem ? LOAD : IDLE;
      done_n  = empty && !(|rem);
    end else if (fire && last) begin
      state_n = has ? LOAD : IDLE;
      done_n  = !has;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      done    <= 1'b0;
      pending <= '0;
      cur     <= '0;
      j       <= '0;
      end_r   <= '0;
    end else begin
      state   <= state_n;
      done    <= done_n;
      // a spike in the same cycle as clear or as its own load survives
      pending <= (clear ? '0 : rem) | spikes;
      if (state == LOAD) begin
        cur   <= sel;
        j     <= j_n;
        end_r <= end_n;
      end else if (fire) j <= j + PTR_W'(1);
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < N_NEURONS; k++) naddr[k] <= '0;
      for (int k = 0; k <= N_NEURONS; k++) ptr[k] <= '0;
      for (int k = 0; k < CONN_DEPTH; k++) conn[k] <= '0;
    end else if (cfg_we && !busy) begin
      if (cfg_sel == 2'd0 && cfg_addr < N_P) naddr[cfg_addr[NW-1:0]] <= cfg_data;
      if (cfg_sel == 2'd1 && cfg_addr <= N_P) ptr[cfg_addr[IW-1:0]] <= cfg_data[PTR_W-1:0];
      if (cfg_sel == 2'd2 && cfg_addr < D_P) conn[cfg_addr[CW-1:0]] <= cfg_data;
    end
  end
endmodule

// File: tb/tb_spike_packet_router.sv
// tb_spike_packet_router: directed checks of fan-out, back-pressure, re-spike, clear, reset and config guard
module tb_spike_packet_router;
  logic CLK = 1'b0, RESET = 1'b1, clear = 1'b0, cfg_we = 1'b0, packet_ready = 1'b0;
  logic [9:0] spikes = '0;
  logic [1:0] cfg_sel = '0;
  logic [5:0] cfg_addr = '0;
  logic [11:0] cfg_data = '0;
  logic [23:0] packet;
  logic packet_valid, busy, done;
  int total = 0, bad = 0, done_cnt = 0;
  logic [23:0] pkts [$];
  always #5 CLK = ~CLK;
  spike_packet_router dut (
    .CLK(CLK), .RESET(RESET), .clear(clear), .spikes(spikes),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .packet(packet), .packet_valid(packet_valid), .packet_ready(packet_ready),
    .busy(busy), .done(done)
  );
  always @(negedge CLK)
    if (!RESET) begin
      if (packet_valid && packet_ready) pkts.push_back(packet);
      if (done) done_cnt++;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic [1:0] s, input int a, input logic [11:0] d);
    cfg_we = 1'b1;
    cfg_sel = s;
    cfg_addr = 6'(a);
    cfg_data = d;
    tick;
    cfg_we = 1'b0;
  endtask
  task automatic spike(input logic [9:0] s);
    spikes = s;
    tick;
    spikes = '0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    tick;
  endtask
  task automatic reset_q;
    pkts.delete();
    done_cnt = 0;
  endtask
  function automatic logic [23:0] pk(input int i);
    return i < pkts.size() ? pkts[i] : 24'h0;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
  initial begin
    #1;
    chk("rst_valid", packet_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_packet", packet, 0);
    tick;
    tick;
    RESET = 1'b0;
    tick;
    wr(0, 2, 12'h0A2); wr(1, 2, 3); wr(1, 3, 6);
    wr(2, 3, 12'h101); wr(2, 4, 12'h102); wr(2, 5, 12'h103);
    wr(0, 5, 12'h0A5); wr(1, 5, 10); wr(1, 6, 12);
    wr(2, 10, 12'h501); wr(2, 11, 12'h502);
    reset_q;
    packet_ready = 1'b1;
    spike(10'h004);
    chk("s1_k0_valid", packet_valid, 0);
    tick;
    chk("s1_load_busy", busy, 1);
    chk("s1_load_valid", packet_valid, 0);
    tick;
    chk("s1_v0", packet_valid, 1);
    chk("s1_p0", packet, 24'h0A2101);
    tick;
    chk("s1_p1", packet, 24'h0A2102);
    tick;
    chk("s1_p2", packet, 24'h0A2103);
    tick;
    chk("s1_done", done, 1);
    chk("s1_idle", busy, 0);
    chk("s1_end_valid", packet_valid, 0);
    tick;
    chk("s1_done_pulse", done, 0);
    chk("s1_cnt", pkts.size(), 3);
    reset_q;
    packet_ready = 1'b0;
    spike(10'h004);
    tick;
    tick;
    chk("s2_v", packet_valid, 1);
    chk("s2_p", packet, 24'h0A2101);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("s2_hold_v", packet_valid, 1);
      chk("s2_hold_p", packet, 24'h0A2101);
    end
    packet_ready = 1'b1;
    wait_idle;
    chk("s2_cnt", pkts.size(), 3);
    chk("s2_q0", pk(0), 24'h0A2101);
    chk("s2_q1", pk(1), 24'h0A2102);
    chk("s2_q2", pk(2), 24'h0A2103);
    chk("s2_done", done_cnt, 1);
    reset_q;
    packet_ready = 1'b1;
    spike(10'h004);
    tick;
    tick;
    spike(10'h004);
    wait_idle;
    chk("s4_cnt", pkts.size(), 6);
    for (int i = 0; i < 6; i++) chk("s4_q", pk(i), 24'h0A2101 + 24'(i % 3));
    chk("s4_done", done_cnt, 1);
    reset_q;
    packet_ready = 1'b0;
    spike(10'h004);
    tick;
    tick;
    chk("s6_busy", busy, 1);
    wr(2, 3, 12'hFFF);
    packet_ready = 1'b1;
    wait_idle;
    chk("s6_cnt", pkts.size(), 3);
    chk("s6_q0", pk(0), 24'h0A2101);
    reset_q;
    spike(10'h004);
    tick;
    tick;
    chk("s6_next", packet, 24'h0A2101);
    wait_idle;
    reset_q;
    packet_ready = 1'b0;
    spike(10'h004);
    tick;
    tick;
    chk("s5_emit", packet_valid, 1);
    clear = 1'b1;
    spikes = 10'h020;
    tick;
    clear = 1'b0;
    spikes = '0;
    chk("s5_drop", packet_valid, 0);
    chk("s5_busy", busy, 0);
    chk("s5_nodone", done, 0);
    packet_ready = 1'b1;
    tick;
    tick;
    chk("s5_first", packet, 24'h0A5501);
    wait_idle;
    chk("s5_cnt", pkts.size(), 2);
    chk("s5_q1", pk(1), 24'h0A5502);
    chk("s5_done", done_cnt, 1);
    wr(0, 0, 12'h0B0); wr(0, 1, 12'h0B1); wr(0, 9, 12'h0B9);
    wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 2); wr(1, 9, 4); wr(1, 10, 5);
    wr(2, 0, 12'h201); wr(2, 1, 12'h202); wr(2, 4, 12'h204);
    reset_q;
    packet_ready = 1'b1;
    spike(10'b1000000011);
    tick;
    tick;
    wait_idle;
    chk("s3_cnt", pkts.size(), 3);
    chk("s3_q0", pk(0), 24'h0B1201);
    chk("s3_q1", pk(1), 24'h0B1202);
    chk("s3_q2", pk(2), 24'h0B9204);
    chk("s3_done", done_cnt, 1);
    reset_q;
    packet_ready = 1'b0;
    spike(10'h004);
    tick;
    tick;
    chk("r_emit", packet_valid, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("r_valid", packet_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_packet", packet, 0);
    tick;
    RESET = 1'b0;
    packet_ready = 1'b1;
    spike(10'h3FF);
    repeat (30) tick;
    chk("r_cnt", pkts.size(), 0);
    chk("r_done", done_cnt, 1);
    chk("r_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_packet_router.md
# spike_packet_router

Parametrised spike-to-packet fan-out engine for the accelerator's network interface. It captures per-neuron spike pulses into a sticky pending vector and walks a CSR (compressed sparse row) connection table for each pending neuron. For every downstream connection it emits one `{source_address, destination_address}` packet over a valid/ready handshake. It replaces the fixed 10-neuron, delay-based packet emitter with a clocked, back-pressure-aware design whose tables are written through a configuration port.

## Interface
- `N_NEURONS`, 10: number of spike inputs / source neurons.
- `ADDR_W`, 12: width of neuron and connection addresses.
- `CONN_DEPTH`, 32: connection table entries.
- `PTR_W`, 6: pointer width; must hold the value `CONN_DEPTH`.

- `CLK` in 1: clock, rising edge.
- `RESET` in 1: reset, asynchronous, active-high.
- `clear` in 1: synchronous timestep clear; flushes pending spikes and aborts the current fan-out.
- `spikes` in N_NEURONS: one-cycle spike pulses; bit i is neuron i.
- `cfg_we` in 1: configuration write strobe.
- `cfg_sel` in 2: target table. 0 = neuron address (N entries), 1 = connection pointer (N+1 entries), 2 = downstream connection (CONN_DEPTH entries), 3 = ignored.
- `cfg_addr` in PTR_W: table index; out-of-range writes are ignored.
- `cfg_data` in ADDR_W: write data; pointer writes use `[PTR_W-1:0]`.
- `packet` out 2*ADDR_W: `{neuron_addr[i], conn[j]}`.
- `packet_valid` out 1: packet presented.
- `packet_ready` in 1: consumer accepts the packet when `packet_valid && packet_ready` at the clock edge.
- `busy` out 1: high when the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when the last pending neuron finishes and the FSM returns to IDLE.

## Operation
- Pending vector update, every edge: `pending <= (clear ? 0 : pending & ~load_clr) | spikes`.
  - A spike that arrives in the same cycle as `clear` is kept.
  - A re-spike of the neuron currently being loaded is kept (set wins).
- FSM states: IDLE, LOAD, EMIT.
  - IDLE: if `pending != 0`, go to LOAD.
  - LOAD:
    - Selects `i` = lowest set pending bit (fixed priority, index 0 highest).
    - Clears `pending[i]` (`load_clr`).
    - Registers `j = ptr[i]` and `end = min(ptr[i+1], CONN_DEPTH)`.
    - If `j >= end` (empty fan-out), go to SCAN-equivalent: IDLE if the remaining pending vector is zero (pulse `done`), else LOAD. No packet is emitted.
    - Otherwise go to EMIT.
  - EMIT:
    - `packet_valid = 1`; `packet = {naddr[i], conn[j]}`.
    - On handshake: `j <= j+1`. If `j+1 == end`, go to LOAD if pending is nonzero, else IDLE with a `done` pulse.
- `clear` in LOAD or EMIT: the next state is IDLE and `packet_valid` drops after the edge. A handshake completing in that same cycle still counts as transferred. No `done` pulse is generated.
- Config writes take effect at the edge. Writes while `busy=1` are ignored; tables are stable during a walk.
- `pending` cannot overflow: a repeated spike on an already-pending neuron merges into one fan-out.

## Timing
- Reset values:
  - `packet = 0`, `packet_valid = 0`, `busy = 0`, `done = 0`.
  - `pending = 0`, FSM in IDLE.
  - All table entries 0, so every fan-out is empty.
- Spike high at edge k: pending is set after edge k, LOAD follows edge k+1, and `packet_valid` is high after edge k+2.
- With `packet_ready` held high: one packet per cycle within a neuron, plus one LOAD bubble cycle between neurons.
- While `packet_valid && !packet_ready`: `packet` is held stable and `valid` stays asserted.
- `done` is asserted in the cycle after the final handshake (or after the final empty LOAD), coincident with IDLE.
- `busy` is high in the LOAD and EMIT states.

## Test plan
1. Neuron 2 fan-out, ready held high:
   - Setup: naddr[2] = 0x0A2, ptr[2] = 3, ptr[3] = 6, conn[3..5] = 0x101, 0x102, 0x103; pulse `spikes[2]`.
   - Required: packets 0x0A2101, 0x0A2102, 0x0A2103 on three consecutive cycles, the first valid 2 cycles after the spike; then `done` for 1 cycle.
2. Back-pressure:
   - Same setup as scenario 1; `ready` low for 4 cycles.
   - Required: 0x0A2101 held stable with `valid` high throughout; no packet lost or duplicated.
3. Simultaneous spikes and empty fan-out:
   - Setup: `spikes = 0b1000000011`, ptr[0] = ptr[1] = 0 (neuron 0 empty), ptr[2] = 2, ptr[9] = 4, ptr[10] = 5.
   - Required: neuron 1 emits conn[0] and conn[1], then neuron 9 emits conn[4]; no packets for neuron 0; one `done`.
4. Re-spike of the active neuron:
   - Pulse `spikes[2]` during EMIT of neuron 2.
   - Required: neuron 2's full sequence is emitted twice.
5. Clear and reset mid-operation:
   - `clear` during EMIT with `spikes[5]` asserted in the same cycle: `valid` drops, then neuron 5 is processed from its first connection, with no `done` from the aborted walk.
   - `RESET` asserted mid-EMIT: `valid = 0` and `busy = 0` immediately, and all tables read back as zero (verified by a spike producing no packets).
6. Config guard:
   - Write conn[3] = 0xFFF while `busy = 1`.
   - Required: the write is ignored and the old value appears in the next walk.
